// File: rtl/calendar_counter.sv
// calendar_counter
//   Calendar date keeper for the alarm clock. Advances one day per day_tick,
//   handles month lengths, leap years and the 4095->0 year wrap, and applies
//   user edits while set_mode is high. Ticks that arrive during set_mode are
//   remembered in a single pending flag and applied once set_mode drops.
//
// Ports
//   clk             in   1   system clock, rising edge
//   reset           in   1   synchronous active-high reset, highest priority
//   day_tick        in   1   one-cycle pulse: advance date by one day
//   set_mode        in   1   1 = edit mode (edits enabled, ticks deferred)
//   inc_day/dec_day in   1   day edit pulses (set_mode only)
//   inc_month/dec_month in 1 month edit pulses (set_mode only)
//   inc_year/dec_year   in 1 year edit pulses (set_mode only)
//   day             out  6   1..last_day
//   month           out  6   0=Jan .. 11=Dec
//   year            out  12  0..4095
//   last_day        out  6   length of the current month (combinational)
//   month_rollover  out  1   one-cycle pulse, month advanced by a tick
//   year_rollover   out  1   one-cycle pulse, Dec 31 -> Jan 1 by a tick
module calendar_counter #(
  parameter int unsigned START_YEAR = 2018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        day_tick,
  input  logic        set_mode,
  input  logic        inc_day,
  input  logic        dec_day,
  input  logic        inc_month,
  input  logic        dec_month,
  input  logic        inc_year,
  input  logic        dec_year,
  output logic [5:0]  day,
  output logic [5:0]  month,
  output logic [11:0] year,
  output logic [5:0]  last_day,
  output logic        month_rollover,
  output logic        year_rollover
);

  typedef enum logic [2:0] {
    ED_NONE,
    ED_INC_DAY,
    ED_DEC_DAY,
    ED_INC_MON,
    ED_DEC_MON,
    ED_INC_YR,
    ED_DEC_YR
  } edit_e;

  logic [5:0]  r_day;
  logic [5:0]  r_month;
  logic [11:0] r_year;
  logic        r_pending;
  logic        r_month_ro;
  logic        r_year_ro;

  logic [5:0]  w_last_day;
  logic [5:0]  w_new_len;
  logic [5:0]  w_day_nx;
  logic [5:0]  w_mon_nx;
  logic [11:0] w_yr_nx;
  logic        w_pend_nx;
  logic        w_mro_nx;
  logic        w_yro_nx;
  edit_e       w_edit;

  function automatic logic is_leap(input logic [11:0] y);
    return (((y % 12'd4) == '0) && ((y % 12'd100) != '0)) ||
           ((y % 12'd400) == '0);
  endfunction

  function automatic logic [5:0] month_len(input logic [5:0] m,
                                           input logic [11:0] y);
    case (m)
      6'd1:                    return is_leap(y) ? 6'd29 : 6'd28;
      6'd3, 6'd5, 6'd8, 6'd10: return 6'd30;
      default:                 return 6'd31;
    endcase
  endfunction

  assign w_last_day = month_len(r_month, r_year);

  // One edit per cycle; the first asserted input in priority order wins.
  always_comb begin
    w_edit = ED_NONE;
    if      (inc_day)   w_edit = ED_INC_DAY;
    else if (dec_day)   w_edit = ED_DEC_DAY;
    else if (inc_month) w_edit = ED_INC_MON;
    else if (dec_month) w_edit = ED_DEC_MON;
    else if (inc_year)  w_edit = ED_INC_YR;
    else if (dec_year)  w_edit = ED_DEC_YR;
  end

  always_comb begin
    w_day_nx  = r_day;
    w_mon_nx  = r_month;
    w_yr_nx   = r_year;
    w_pend_nx = r_pending;
    w_mro_nx  = 1'b0;
    w_yro_nx  = 1'b0;
    w_new_len = '0;

    if (!set_mode) begin
      // A live tick and a pending tick in the same cycle: the live one is
      // applied now and the pending one is kept for the next cycle.
      w_pend_nx = r_pending & day_tick;
      if (day_tick || r_pending) begin
        if (r_day < w_last_day) begin
          w_day_nx = r_day + 6'd1;
        end else begin
          w_day_nx = 6'd1;
          w_mro_nx = 1'b1;
          if (r_month >= 6'd11) begin
            w_mon_nx = '0;
            w_yr_nx  = r_year + 12'd1;
            w_yro_nx = 1'b1;
          end else begin
            w_mon_nx = r_month + 6'd1;
          end
        end
      end
    end else begin
      w_pend_nx = r_pending | day_tick;
      case (w_edit)
        ED_INC_DAY: w_day_nx = (r_day >= w_last_day) ? 6'd1 : r_day + 6'd1;
        ED_DEC_DAY: w_day_nx = (r_day <= 6'd1) ? w_last_day : r_day - 6'd1;
        ED_INC_MON: w_mon_nx = (r_month >= 6'd11) ? 6'd0 : r_month + 6'd1;
        ED_DEC_MON: w_mon_nx = (r_month == 6'd0) ? 6'd11 : r_month - 6'd1;
        ED_INC_YR:  w_yr_nx  = r_year + 12'd1;
        ED_DEC_YR:  w_yr_nx  = r_year - 12'd1;
        default:    ;
      endcase
      // Clamp against the length of the resulting month; a no-op for day edits.
      w_new_len = month_len(w_mon_nx, w_yr_nx);
      if (w_day_nx > w_new_len) w_day_nx = w_new_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_day      <= 6'd1;
      r_month    <= '0;
      r_year     <= 12'(START_YEAR);
      r_pending  <= 1'b0;
      r_month_ro <= 1'b0;
      r_year_ro  <= 1'b0;
    end else begin
      r_day      <= w_day_nx;
      r_month    <= w_mon_nx;
      r_year     <= w_yr_nx;
      r_pending  <= w_pend_nx;
      r_month_ro <= w_mro_nx;
      r_year_ro  <= w_yro_nx;
    end
  end

  assign day            = r_day;
  assign month          = r_month;
  assign year           = r_year;
  assign last_day       = w_last_day;
  assign month_rollover = r_month_ro;
  assign year_rollover  = r_year_ro;

endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench for calendar_counter: directed date scenarios with
// literal expectations plus randomized ticks/edits/resets compared every
// cycle against a date-arithmetic model.
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        day_tick = 1'b0;
  logic        set_mode = 1'b0;
  logic        inc_day = 1'b0, dec_day = 1'b0;
  logic        inc_month = 1'b0, dec_month = 1'b0;
  logic        inc_year = 1'b0, dec_year = 1'b0;
  logic [5:0]  day, month, last_day;
  logic [11:0] year;
  logic        month_rollover, year_rollover;

  int errors = 0;
  int checks = 0;

  // model state
  int md, mm, my;
  bit mp, mmro, myro, mv = 1'b0;

  calendar_counter #(.START_YEAR(2018)) dut (
    .clk(clk), .reset(reset), .day_tick(day_tick), .set_mode(set_mode),
    .inc_day(inc_day), .dec_day(dec_day), .inc_month(inc_month),
    .dec_month(dec_month), .inc_year(inc_year), .dec_year(dec_year),
    .day(day), .month(month), .year(year), .last_day(last_day),
    .month_rollover(month_rollover), .year_rollover(year_rollover)
  );

  always #5 clk = ~clk;

  function automatic bit leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(int m, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 1 && leap(y)) return 29;
    return t[m];
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: calendar arithmetic straight from the date rules.
  always @(posedge clk) begin
    bit adv;
    if (reset) begin
      md = 1; mm = 0; my = 2018; mp = 0; mmro = 0; myro = 0; mv = 1;
    end else if (mv) begin
      mmro = 0; myro = 0;
      if (!set_mode) begin
        adv = day_tick || mp;
        mp  = mp && day_tick;
        if (adv) begin
          md++;
          if (md > dim(mm, my)) begin
            md = 1; mm++; mmro = 1;
            if (mm == 12) begin mm = 0; my = (my + 1) % 4096; myro = 1; end
          end
        end
      end else begin
        if (day_tick) mp = 1;
        if (inc_day)        md = md % dim(mm, my) + 1;
        else if (dec_day)   md = (md == 1) ? dim(mm, my) : md - 1;
        else if (inc_month) mm = (mm + 1) % 12;
        else if (dec_month) mm = (mm + 11) % 12;
        else if (inc_year)  my = (my + 1) % 4096;
        else if (dec_year)  my = (my + 4095) % 4096;
        if (md > dim(mm, my)) md = dim(mm, my);
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      cmp("day", int'(day), md);
      cmp("month", int'(month), mm);
      cmp("year", int'(year), my);
      cmp("last_day", int'(last_day), dim(mm, my));
      cmp("month_rollover", int'(month_rollover), int'(mmro));
      cmp("year_rollover", int'(year_rollover), int'(myro));
    end
  end

  // ed = {inc_day, dec_day, inc_month, dec_month, inc_year, dec_year}
  task automatic drive(input logic rst, input logic tk, input logic sm,
                       input logic [5:0] ed);
    reset = rst; day_tick = tk; set_mode = sm;
    {inc_day, dec_day, inc_month, dec_month, inc_year, dec_year} = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 6'b0);
  endtask

  task automatic set_date(input int d, input int m, input int y);
    int n = 0;
    while (my != y && n < 5000) begin
      drive(1'b0, 1'b0, 1'b1, (y > my) ? 6'b000010 : 6'b000001);
      n++;
    end
    while (mm != m && n < 5000) begin drive(1'b0, 1'b0, 1'b1, 6'b001000); n++; end
    while (md != d && n < 5000) begin drive(1'b0, 1'b0, 1'b1, 6'b100000); n++; end
    cmp("set_date_bound", int'(n < 5000), 1);
    idle();
  endtask

  initial begin
    logic sm;
    logic [5:0] ed;
    drive(1'b1, 1'b0, 1'b0, 6'b0);
    drive(1'b1, 1'b0, 1'b0, 6'b0);
    cmp("rst_day", int'(day), 1);
    cmp("rst_month", int'(month), 0);
    cmp("rst_year", int'(year), 2018);
    idle();

    // Jan 1 + 30 ticks -> Jan 31, + 1 -> Feb 1 with month pulse
    repeat (30) drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("jan31_day", int'(day), 31);
    cmp("jan31_month", int'(month), 0);
    drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("feb1_day", int'(day), 1);
    cmp("feb1_month", int'(month), 1);
    cmp("feb1_mro", int'(month_rollover), 1);
    idle();
    cmp("feb1_mro_low", int'(month_rollover), 0);

    // Leap-year February ends
    set_date(28, 1, 2018); drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("2018_feb28_tick_day", int'(day), 1);
    cmp("2018_feb28_tick_mon", int'(month), 2);
    set_date(28, 1, 2020); drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("2020_feb29", int'(day), 29);
    drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("2020_mar1_day", int'(day), 1);
    cmp("2020_mar1_mon", int'(month), 2);
    set_date(28, 1, 1900); drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("1900_mon", int'(month), 2);
    set_date(28, 1, 2000); drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("2000_day", int'(day), 29);
    idle();

    // Year rollover and 4095 wrap
    set_date(31, 11, 2018); drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("ny_day", int'(day), 1);
    cmp("ny_month", int'(month), 0);
    cmp("ny_year", int'(year), 2019);
    cmp("ny_mro", int'(month_rollover), 1);
    cmp("ny_yro", int'(year_rollover), 1);
    idle();
    cmp("ny_yro_low", int'(year_rollover), 0);
    set_date(31, 11, 4095); drive(1'b0, 1'b1, 1'b0, 6'b0);
    cmp("wrap_year", int'(year), 0);

    // Deferred ticks collapse into one advance
    drive(1'b1, 1'b0, 1'b0, 6'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 6'b0);
    cmp("pend_hold_day", int'(day), 1);
    idle();
    cmp("pend_apply_day", int'(day), 2);
    idle(); idle();
    cmp("pend_once_day", int'(day), 2);

    // Month edit clamps; priority keeps only the day edit
    set_date(31, 0, 2018);
    drive(1'b0, 1'b0, 1'b1, 6'b001000);
    cmp("clamp_day", int'(day), 28);
    cmp("clamp_month", int'(month), 1);
    drive(1'b0, 1'b0, 1'b1, 6'b100010);
    cmp("prio_day", int'(day), 1);
    cmp("prio_year", int'(year), 2018);
    idle();

    // Reset beats a live tick and a pending tick
    drive(1'b0, 1'b1, 1'b1, 6'b0);
    drive(1'b1, 1'b1, 1'b0, 6'b0);
    cmp("rst_tick_day", int'(day), 1);
    cmp("rst_tick_mro", int'(month_rollover), 0);
    idle(); idle();
    cmp("rst_no_pend_day", int'(day), 1);

    // Randomized traffic
    sm = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) sm = ~sm;
      ed = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'b0;
      drive(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 1)),
            sm, ed);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
